// File: rtl/epu_pkg.sv
// Shared constants and types for the EPU buffer loader slice.
package epu_pkg;

  localparam int unsigned WORD_W          = 128;
  localparam int unsigned ADDR_W          = 12;
  localparam int unsigned WORDS_PER_BLOCK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    KICK = 2'd2,
    RUN  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/epu_buf_loader_if.sv
// DMA stream, engine control and engine read bus for the buffer loader.
// master = DMA/engine side, slave = loader.
interface epu_buf_loader_if;
  import epu_pkg::*;

  logic              load_req;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              start;
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data_read;
  logic              alg_done;
  logic              buf_done;
  logic [ADDR_W-1:0] fill_cnt;
  logic              addr_err;

  modport master (
    output load_req, in_valid, in_data, read, addr, alg_done,
    input  in_ready, start, data_read, buf_done, fill_cnt, addr_err
  );

  modport slave (
    input  load_req, in_valid, in_data, read, addr, alg_done,
    output in_ready, start, data_read, buf_done, fill_cnt, addr_err
  );

endinterface

// File: rtl/epu_buf_ram.sv
// Single-clock simple dual-port word array: one write port, one registered
// read port that returns the pre-write contents on a same-address collision.
// No reset, so it maps directly onto an SRAM macro.
module epu_buf_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned W     = 128
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // Write and registered read; the read samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/epu_buf_loader.sv
// EPU buffer loader: fills a 16*BLOCK_NUM word buffer from the DMA stream,
// kicks the algorithm engine, serves its reads and waits for completion.
module epu_buf_loader
  import epu_pkg::*;
#(
  parameter int unsigned BLOCK_NUM = 64
) (
  input  logic              clk,
  input  logic              rst,
  epu_buf_loader_if.slave   bus
);

  localparam int unsigned       DEPTH    = WORDS_PER_BLOCK * BLOCK_NUM;
  localparam int unsigned       RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              start_q, start_d;
  logic              buf_done_q, buf_done_d;
  logic              addr_err_q, addr_err_d;
  logic              rd_ok_q, rd_ok_d;

  logic              wr_en;
  logic              addr_oob;
  logic [WORD_W-1:0] ram_rdata;

  assign wr_en    = (state_q == FILL) && bus.in_valid && in_ready_q;
  assign addr_oob = {1'b0, bus.addr} >= DEPTH_X;

  // Next-state, fill counter and registered handshake/pulse outputs.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    buf_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      end
      FILL: begin
        if (wr_en) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST_IDX) state_d = KICK;
        end
      end
      KICK: state_d = RUN;
      RUN: begin
        if (bus.alg_done) begin
          state_d    = IDLE;
          buf_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // in_ready/start follow the state being entered so they are flop outputs.
    in_ready_d = (state_d == FILL);
    start_d    = (state_d == KICK);
  end

  // Read qualification and sticky out-of-range error.
  always_comb begin
    rd_ok_d    = bus.read && !addr_oob;
    addr_err_d = addr_err_q || (bus.read && addr_oob);
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      in_ready_q <= 1'b0;
      start_q    <= 1'b0;
      buf_done_q <= 1'b0;
      addr_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      buf_done_q <= buf_done_d;
      addr_err_q <= addr_err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  epu_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW),
    .W     (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (fill_cnt_q[RAM_AW-1:0]),
    .wdata (bus.in_data),
    .re    (rd_ok_d),
    .raddr (bus.addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // The RAM holds its last word when not read, so a registered qualifier
  // forces zero for idle cycles and out-of-range reads.
  assign bus.data_read = rd_ok_q ? ram_rdata : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.start     = start_q;
  assign bus.buf_done  = buf_done_q;
  assign bus.fill_cnt  = fill_cnt_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_epu_buf_loader.sv
// Randomized bench for epu_buf_loader (BLOCK_NUM=2, DEPTH=32) against a
// transaction-level reference model.
module tb_epu_buf_loader;
  import epu_pkg::*;

  localparam int unsigned BN    = 2;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  epu_buf_loader_if bus();

  epu_buf_loader #(.BLOCK_NUM(BN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: buffer contents plus which phase of the load cycle we are in.
  logic [127:0] mem_m [DEPTH];
  bit           m_filling, m_kick, m_run, m_done, m_err;
  int           m_cnt;
  logic [127:0] m_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("in_ready",  128'(bus.in_ready),  128'(m_filling));
    check_eq("start",     128'(bus.start),     128'(m_kick));
    check_eq("buf_done",  128'(bus.buf_done),  128'(m_done));
    check_eq("fill_cnt",  128'(bus.fill_cnt),  128'(m_cnt));
    check_eq("data_read", bus.data_read,       m_data);
    check_eq("addr_err",  128'(bus.addr_err),  128'(m_err));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input bit lr, input bit iv, input logic [127:0] d,
                     input bit rd, input int a, input bit ad);
    bus.load_req = lr;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.read     = rd;
    bus.addr     = 12'(a);
    bus.alg_done = ad;

    m_data = (rd && a < DEPTH) ? mem_m[a] : '0;
    if (rd && a >= DEPTH) m_err = 1'b1;
    m_done = 1'b0;
    if (m_filling) begin
      if (iv) begin
        mem_m[m_cnt] = d;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_filling = 1'b0;
          m_kick    = 1'b1;
        end
      end
    end else if (m_kick) begin
      m_kick = 1'b0;
      m_run  = 1'b1;
    end else if (m_run) begin
      if (ad) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end else if (lr) begin
      m_filling = 1'b1;
      m_cnt     = 0;
    end

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b1;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.read     = 1'b0;
    bus.addr     = '0;
    bus.alg_done = 1'b0;
    m_filling = 1'b0; m_kick = 1'b0; m_run = 1'b0; m_done = 1'b0;
    m_err = 1'b0; m_cnt = 0; m_data = '0;
    #1;
    check_outputs();
    repeat (cycles) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  // Arm and fill the buffer. base<0 selects random data; gaps throttles in_valid;
  // rd_live issues reads (often colliding with the write address) during the fill.
  task automatic load(input longint base, input bit gaps, input bit rd_live);
    int guard = 0;
    cyc(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    while (m_filling && guard < 400) begin
      bit iv;
      bit rd;
      int a;
      logic [127:0] d;
      iv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d  = (base < 0) ? rand128() : 128'(base + m_cnt);
      rd = rd_live ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = ($urandom_range(0, 1) == 1) ? m_cnt : int'($urandom_range(0, DEPTH - 1));
      cyc(1'b0, iv, d, rd, a, 1'b0);
      guard++;
    end
  endtask

  task automatic read_all();
    for (int unsigned a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, '0, 1'b1, int'(a), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    // 1. reset then idle: in_valid without load_req is ignored
    do_reset(2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, rand128(), 1'b0, 0, 1'b0);

    // 2. full back-to-back load with in_data=i; stray words in KICK/RUN ignored
    load(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, rand128(), 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);

    // 3. throttled load, then read every word back, then read=0
    load(0, 1'b1, 1'b0);
    read_all();

    // 4. out-of-range reads set a sticky error; valid reads still work
    cyc(1'b0, 1'b0, '0, 1'b1, DEPTH, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 4095, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 1'b1, int'($urandom_range(0, DEPTH - 1)), 1'b0);

    // 5. completion, load_req in RUN ignored, re-arm with 100+i and live reads
    cyc(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);
    load(100, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    read_all();
    cyc(1'b0, 1'b0, '0, 1'b0, 0, 1'b1);

    // 6. reset after 10 words abandons the fill; a fresh load then completes
    cyc(1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, rand128(), 1'b0, 0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, rand128(), 1'b0, 0, 1'b0);
    load(0, 1'b0, 1'b0);
    read_all();

    // Random soak over all inputs, random data, in- and out-of-range reads.
    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                      : int'($urandom_range(0, DEPTH - 1));
      cyc(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), rand128(),
          1'($urandom_range(0, 1)), a, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
